// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_dac_tx
// Purpose  : Stereo I2S master transmitter. Derives BCLK/LRCK from clk,
//            serializes one left/right PCM pair per frame MSB first with the
//            standard one-BCLK delay, and fills silence on underrun.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_dac_tx #(
  parameter int DATA_W    = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_dacdat,
  output logic              frame_start,
  output logic [15:0]       underrun_count
);

  localparam int c_div_w = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int c_bit_w = $clog2(2 * SLOT_BITS);

  localparam logic [0:0] c_s_idle = 1'b0;
  localparam logic [0:0] c_s_run  = 1'b1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(BCLK_DIV / 2);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(2 * SLOT_BITS - 1);
  localparam logic [c_bit_w-1:0] c_slot     = c_bit_w'(SLOT_BITS);
  localparam logic [c_bit_w-1:0] c_data_w   = c_bit_w'(DATA_W);

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [c_div_w-1:0] r_div;
  logic [c_bit_w-1:0] r_bit;
  logic               r_bclk;
  logic               r_lrck;
  logic               r_dat;
  logic               r_fs;
  logic [15:0]        r_underrun;
  logic               r_hold_full;
  logic [DATA_W-1:0]  r_hold_l;
  logic [DATA_W-1:0]  r_hold_r;
  logic [DATA_W-1:0]  r_sh_l;
  logic [DATA_W-1:0]  r_sh_r;

  logic [c_div_w-1:0] w_div_next;
  logic [c_bit_w-1:0] w_bit_next;
  logic [c_bit_w-1:0] w_slot_pos;
  logic [c_bit_w-1:0] w_idx;
  logic [DATA_W-1:0]  w_sel;
  logic [DATA_W-1:0]  w_shifted;
  logic               w_load;
  logic               w_entry;
  logic               w_keep;
  logic               w_xfer;
  logic               w_bclk_next;
  logic               w_lrck_next;
  logic               w_dat_next;

  // Hold may accept a pair only while running with an empty holding register
  assign sample_ready   = (r_state == c_s_run) && !r_hold_full;
  assign w_xfer         = sample_valid && sample_ready;
  // Holding register survives only while running and still locked
  assign w_keep         = (r_state == c_s_run) && pll_locked;

  assign i2s_bclk       = r_bclk;
  assign i2s_lrck       = r_lrck;
  assign i2s_dacdat     = r_dat;
  assign frame_start    = r_fs;
  assign underrun_count = r_underrun;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_s_idle;
    else     r_state <= w_state_next;
  end

  // Next-state logic: run exactly while the PLL reports lock
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_s_idle: if (pll_locked)  w_state_next = c_s_run;
      c_s_run:  if (!pll_locked) w_state_next = c_s_idle;
      default:                   w_state_next = c_s_idle;
    endcase
  end

  // Output logic: next divider/bit position and the registered pin values
  always_comb begin
    w_div_next  = '0;
    w_bit_next  = '0;
    w_load      = 1'b0;
    w_entry     = 1'b0;
    w_bclk_next = 1'b0;
    w_lrck_next = 1'b0;
    w_dat_next  = 1'b0;
    w_slot_pos  = '0;
    w_idx       = '0;
    w_sel       = '0;
    w_shifted   = '0;
    case (r_state)
      c_s_idle: begin
        // Entering RUN is itself a falling edge and a (silent) frame load
        if (pll_locked) begin
          w_load  = 1'b1;
          w_entry = 1'b1;
        end
      end
      c_s_run: begin
        if (pll_locked) begin
          if (r_div == c_div_last) begin
            w_div_next = '0;
            w_bit_next = (r_bit == c_bit_last) ? '0 : r_bit + 1'b1;
            w_load     = (r_bit == c_bit_last);
          end else begin
            w_div_next = r_div + 1'b1;
            w_bit_next = r_bit;
          end
          w_bclk_next = (w_div_next >= c_div_half);
          w_lrck_next = (w_bit_next >= c_slot);
          if (w_bit_next >= c_slot) begin
            w_slot_pos = w_bit_next - c_slot;
            w_sel      = r_sh_r;
          end else begin
            w_slot_pos = w_bit_next;
            w_sel      = r_sh_l;
          end
          // One-BCLK delay: slot position 1 carries the MSB
          w_idx     = c_data_w - w_slot_pos;
          w_shifted = w_sel >> w_idx;
          if ((w_slot_pos != '0) && (w_slot_pos <= c_data_w))
            w_dat_next = w_shifted[0];
        end
      end
      default: ;
    endcase
  end

  // Datapath: pins, counters, holding/shift registers and underrun counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_bit       <= '0;
      r_bclk      <= 1'b0;
      r_lrck      <= 1'b0;
      r_dat       <= 1'b0;
      r_fs        <= 1'b0;
      r_underrun  <= '0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
    end else begin
      r_div  <= w_div_next;
      r_bit  <= w_bit_next;
      r_bclk <= w_bclk_next;
      r_lrck <= w_lrck_next;
      r_dat  <= w_dat_next;
      r_fs   <= w_load;
      // Load sees the pre-transfer holding state
      if (w_load) begin
        if (r_hold_full && !w_entry) begin
          r_sh_l <= r_hold_l;
          r_sh_r <= r_hold_r;
        end else begin
          r_sh_l <= '0;
          r_sh_r <= '0;
          if (!w_entry && (r_underrun != 16'hFFFF))
            r_underrun <= r_underrun + 16'd1;
        end
      end
      if (!w_keep)      r_hold_full <= 1'b0;
      else if (w_xfer)  r_hold_full <= 1'b1;
      else if (w_load)  r_hold_full <= 1'b0;
      if (w_xfer) begin
        r_hold_l <= sample_left;
        r_hold_r <= sample_right;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_dac_tx
// Purpose  : Self-checking bench for i2s_dac_tx. A frame-level reference model
//            predicts each frame's L/R content into a queue; a monitor decodes
//            the serial pins into frames and compares against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_dac_tx;

  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * SLOT * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic [DW-1:0] sample_left;
  logic [DW-1:0] sample_right;
  logic          sample_valid;
  logic          sample_ready;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_dacdat;
  logic          frame_start;
  logic [15:0]   underrun_count;

  always #5 clk = ~clk;

  i2s_dac_tx #(.DATA_W(DW), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrck       (i2s_lrck),
    .i2s_dacdat     (i2s_dacdat),
    .frame_start    (frame_start),
    .underrun_count (underrun_count)
  );

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    bit            aborted;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  bit     chk_en = 0;

  // Reference model state: running flag, position in frame, holding slot
  bit            m_run  = 0;
  int            m_pos  = 0;
  bit            m_full = 0;
  logic [DW-1:0] m_hl   = '0;
  logic [DW-1:0] m_hr   = '0;
  int            m_under = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: check per-cycle pin levels, then advance to the next cycle
  always @(negedge clk) begin
    frame_t e;
    bit     xfer;
    if (chk_en) begin
      check("bclk",   i2s_bclk,    m_run && ((m_pos % DIV) >= DIV / 2));
      check("lrck",   i2s_lrck,    m_run && (m_pos >= FRAME / 2));
      check("fstart", frame_start, m_run && (m_pos == 0));
      check("ready",  sample_ready, m_run && !m_full);
      check("underrun", underrun_count, m_under);
      if (!m_run) check("dacdat_idle", i2s_dacdat, 0);
    end
    if (rst) begin
      m_run = 0; m_full = 0; m_under = 0; m_pos = 0;
    end else if (!m_run) begin
      if (pll_locked) begin
        m_run = 1; m_pos = 0;
        e.l = '0; e.r = '0; e.aborted = 0;
        exp_q.push_back(e);
      end
    end else if (!pll_locked) begin
      // The monitor has all 64 bits once bit 63 has been sampled (pos 254)
      if (m_pos < FRAME - 2 && exp_q.size() > 0)
        exp_q[exp_q.size() - 1].aborted = 1;
      m_run = 0; m_full = 0;
    end else begin
      xfer  = sample_valid && !m_full;
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) begin
        e.aborted = 0;
        if (m_full) begin
          e.l = m_hl; e.r = m_hr; m_full = 0;
        end else begin
          e.l = '0; e.r = '0;
          if (m_under < 65535) m_under++;
        end
        exp_q.push_back(e);
      end
      if (xfer) begin
        m_full = 1; m_hl = sample_left; m_hr = sample_right;
      end
    end
  end

  // Monitor: rebuild frames from the serial pins and score them
  int            nbits = 0;
  bit            in_frame = 0;
  logic          prev_bclk = 1'b0;
  logic [63:0]   bits;
  always @(negedge clk) begin
    frame_t        e;
    logic [DW-1:0] gl, gr;
    logic          pad;
    if (chk_en) begin
      if (frame_start) begin
        if (in_frame) begin
          if (exp_q.size() == 0) check("queue_empty_abort", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("frame_aborted", e.aborted, 1);
          end
        end
        in_frame = 1; nbits = 0;
      end
      if (in_frame && i2s_bclk && !prev_bclk) begin
        bits[nbits] = i2s_dacdat;
        nbits++;
        if (nbits == 2 * SLOT) begin
          in_frame = 0;
          gl = '0; gr = '0; pad = 1'b0;
          for (int i = 0; i < 2 * SLOT; i++) begin
            if ((i % SLOT) >= 1 && (i % SLOT) <= DW) begin
              if (i < SLOT) gl[DW - i] = bits[i];
              else          gr[DW - (i - SLOT)] = bits[i];
            end else begin
              pad = pad | bits[i];
            end
          end
          if (exp_q.size() == 0) check("queue_empty_frame", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("frame_complete", e.aborted, 0);
            check("left",  gl, e.l);
            check("right", gr, e.r);
            check("pad_zero", pad, 0);
          end
        end
      end
    end
    prev_bclk = i2s_bclk;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Return just after the posedge that starts frame position p
  task automatic goto_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(m_run && m_pos == p) && n < 4 * FRAME);
    if (n >= 4 * FRAME) check("goto_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n = 0;
    sample_valid = 1'b1; sample_left = l; sample_right = r;
    do begin
      @(negedge clk); n++;
    end while (!sample_ready && n < 4 * FRAME);
    if (n >= 4 * FRAME) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pll_locked = 1'b0; sample_valid = 1'b0;
    sample_left = '0; sample_right = '0;
    cycles(2);
    chk_en = 1;
    cycles(3);
    rst = 1'b0;
    cycles(95);
    @(negedge clk); #1;
    check("reset_underrun", underrun_count, 0);
    cycles(1);

    // Lock and feed one known pair during frame 0
    pll_locked = 1'b1;
    goto_pos(20);
    send(24'hABCDEF, 24'h123456);
    cycles(2 * FRAME);

    // Starve for four frames
    cycles(4 * FRAME);

    // Back-to-back pairs with valid held high
    send(24'h111111, 24'h222222);
    send(24'h333333, 24'h444444);
    cycles(3 * FRAME);

    // Valid in the cycle that ends on a frame load, then in a frame_start cycle
    goto_pos(FRAME - 1);
    send(24'h5A5A5A, 24'hA5A5A5);
    cycles(3 * FRAME);
    goto_pos(0);
    send(24'h0F0F0F, 24'hF0F0F0);
    cycles(3 * FRAME);

    // Lose lock at bit 40 with a pair waiting in the holding register
    goto_pos(10);
    send(24'h777777, 24'h888888);
    goto_pos(40 * DIV);
    pll_locked = 1'b0;
    @(negedge clk); #1;
    cycles(20);
    pll_locked = 1'b1;
    cycles(3 * FRAME);

    // Saturation of the underrun counter
    goto_pos(100);
    @(negedge clk); #2;
    force dut.r_underrun = 16'hFFFE;
    m_under = 16'hFFFE;
    #1;
    release dut.r_underrun;
    cycles(3 * FRAME + 20);
    @(negedge clk); #1;
    check("underrun_sat", underrun_count, 16'hFFFF);
    cycles(1);

    // Randomized traffic with one unplanned lock loss
    for (int it = 0; it < 25; it++) begin
      cycles($urandom_range(0, 400));
      send(DW'($urandom), DW'($urandom));
      if (it == 12) begin
        goto_pos($urandom_range(1, FRAME - 3));
        pll_locked = 1'b0;
        cycles($urandom_range(5, 50));
        pll_locked = 1'b1;
      end
    end
    cycles(2 * FRAME + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
